// File: rtl/miner_pkg.sv
// miner_pkg: shared state and drain-reason types for the multi-core mining scheduler
package miner_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_t;
    typedef enum logic [1:0] {FOUND, EXHAUST, ABORT} drain_reason_t;
endpackage

// File: rtl/rr_idle_picker.sv
// rr_idle_picker: combinational round-robin pick of the first idle core at or above rrPtr
//   idleMask   - one bit per core, 1 = core free to launch
//   rrPtr      - index where the upward search begins (wraps)
//   grantIdx   - selected core index
//   grantValid - at least one core is idle
module rr_idle_picker
    import miner_pkg::*;
#(
    parameter int NUM_CORES = 4,
    localparam int IDX_W = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0] idleMask,
    input  logic [IDX_W-1:0]     rrPtr,
    output logic [IDX_W-1:0]     grantIdx,
    output logic                 grantValid
);
    logic [2*NUM_CORES-1:0] doubled;
    logic [NUM_CORES-1:0]   rotated;
    logic [IDX_W:0]         sum;

    // Rotating the mask so bit 0 is rrPtr turns the wrapped search into a
    // plain lowest-set-bit search; the offset is added back modulo NUM_CORES.
    always_comb begin
        doubled = {idleMask, idleMask} >> rrPtr;
        rotated = doubled[NUM_CORES-1:0];
        grantValid = |rotated;
        sum = '0;
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            if (rotated[j]) sum = {1'b0, rrPtr} + (IDX_W+1)'(j);
        end
        grantIdx = (sum >= (IDX_W+1)'(NUM_CORES)) ? IDX_W'(sum - (IDX_W+1)'(NUM_CORES)) : IDX_W'(sum);
    end
endmodule

// File: rtl/mining_scheduler.sv
// mining_scheduler: dispatches ascending nonces to NUM_CORES SHA cores and collects the first winner
//   clk, n_rst              - clock, async active-low reset
//   start, abort            - job control pulses (start honoured in IDLE, abort in RUN)
//   core_done, core_valid   - per-core completion pulse and comparator verdict
//   core_start, core_nonce  - one-hot launch pulse and the nonce the core latches
//   busy                    - any state other than IDLE
//   found, found_nonce      - sticky first winner
//   exhausted               - sticky: whole nonce space tried without a winner
//   hash_count              - saturating count of completed hashes this job
module mining_scheduler
    import miner_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W = 32
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] core_valid,
    output logic [NUM_CORES-1:0] core_start,
    output logic [NONCE_W-1:0]   core_nonce,
    output logic                 busy,
    output logic                 found,
    output logic [NONCE_W-1:0]   found_nonce,
    output logic                 exhausted,
    output logic [31:0]          hash_count
);
    localparam int IDX_W = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;

    sched_state_t         state, stateNext;
    drain_reason_t        reason, reasonNext;
    logic [NUM_CORES-1:0] coreBusy, doneAcc, winMask;
    logic [NONCE_W-1:0]   coreTag [NUM_CORES];
    logic [NONCE_W-1:0]   nextNonce;
    logic                 allIssued, winner, launch, grantValid, startAcc;
    logic [IDX_W-1:0]     rrPtr, grantIdx, winIdx;
    logic [31:0]          doneCount;
    logic [32:0]          hashSum;

    rr_idle_picker #(.NUM_CORES(NUM_CORES)) picker (
        .idleMask(~coreBusy),
        .rrPtr(rrPtr),
        .grantIdx(grantIdx),
        .grantValid(grantValid)
    );

    // Completions on idle cores are dropped; only RUN may declare a winner so
    // late valid results during DRAIN cannot overwrite the first one.
    always_comb begin
        doneAcc = core_done & coreBusy;
        winMask = doneAcc & core_valid;
        winner = (state == RUN) && (|winMask);
        winIdx = '0;
        doneCount = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (winMask[i]) winIdx = IDX_W'(i);
            doneCount = doneCount + 32'(doneAcc[i]);
        end
        hashSum = {1'b0, hash_count} + {1'b0, doneCount};
        startAcc = (state == IDLE) && start;
        launch = (state == RUN) && !allIssued && grantValid && !winner && !abort;
        core_start = launch ? (NUM_CORES'(1) << grantIdx) : '0;
        core_nonce = launch ? nextNonce : '0;
        busy = (state != IDLE);
    end

    always_comb begin
        stateNext = state;
        reasonNext = reason;
        case (state)
            IDLE: if (start) stateNext = RUN;
            RUN: begin
                if (winner) begin
                    stateNext = DRAIN;
                    reasonNext = FOUND;
                end else if (abort) begin
                    stateNext = DRAIN;
                    reasonNext = ABORT;
                end else if (allIssued && coreBusy == '0) begin
                    stateNext = DRAIN;
                    reasonNext = EXHAUST;
                end
            end
            DRAIN: if (coreBusy == '0) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            reason <= FOUND;
            coreBusy <= '0;
            nextNonce <= '0;
            allIssued <= 1'b0;
            rrPtr <= '0;
            found <= 1'b0;
            found_nonce <= '0;
            exhausted <= 1'b0;
            hash_count <= '0;
            for (int i = 0; i < NUM_CORES; i++) coreTag[i] <= '0;
        end else begin
            state <= stateNext;
            reason <= reasonNext;
            coreBusy <= (coreBusy & ~doneAcc) | core_start;
            hash_count <= hashSum[32] ? '1 : hashSum[31:0];
            if (launch) begin
                coreTag[grantIdx] <= nextNonce;
                rrPtr <= (grantIdx == IDX_W'(NUM_CORES - 1)) ? '0 : grantIdx + IDX_W'(1);
                // The last nonce is issued once; the counter parks instead of wrapping.
                if (&nextNonce) allIssued <= 1'b1;
                else nextNonce <= nextNonce + NONCE_W'(1);
            end
            if (winner) begin
                found <= 1'b1;
                found_nonce <= coreTag[winIdx];
            end
            if (state == DRAIN && reason == EXHAUST && coreBusy == '0) exhausted <= 1'b1;
            if (startAcc) begin
                found <= 1'b0;
                found_nonce <= '0;
                exhausted <= 1'b0;
                hash_count <= '0;
                nextNonce <= '0;
                allIssued <= 1'b0;
                rrPtr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mining_scheduler.sv
// tb_mining_scheduler: directed scoreboard bench for mining_scheduler (4x32 and 2x4 builds)
module tb_mining_scheduler;
    logic clk = 1'b0;
    logic n_rst;

    logic        aStart, aAbort, aBusy, aFound, aExh;
    logic [3:0]  aDone, aValid, aCoreStart;
    logic [31:0] aNonce, aFoundNonce, aHash;

    logic        bStart, bAbort, bBusy, bFound, bExh;
    logic [1:0]  bDone, bValid, bCoreStart;
    logic [3:0]  bNonce, bFoundNonce, bLast;
    logic [31:0] bHash;

    int total = 0;
    int bad = 0;
    int bLaunches = 0;
    int bCnt [2];
    logic bEnded;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] nonce;
    } launchRec;
    launchRec   qA[$];
    logic [3:0] qB[$];

    always #5 clk = ~clk;

    mining_scheduler #(.NUM_CORES(4), .NONCE_W(32)) dutA (
        .clk(clk), .n_rst(n_rst), .start(aStart), .abort(aAbort),
        .core_done(aDone), .core_valid(aValid), .core_start(aCoreStart),
        .core_nonce(aNonce), .busy(aBusy), .found(aFound),
        .found_nonce(aFoundNonce), .exhausted(aExh), .hash_count(aHash)
    );

    mining_scheduler #(.NUM_CORES(2), .NONCE_W(4)) dutB (
        .clk(clk), .n_rst(n_rst), .start(bStart), .abort(bAbort),
        .core_done(bDone), .core_valid(bValid), .core_start(bCoreStart),
        .core_nonce(bNonce), .busy(bBusy), .found(bFound),
        .found_nonce(bFoundNonce), .exhausted(bExh), .hash_count(bHash)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushA(input logic [3:0] mask, input logic [31:0] nonce);
        launchRec r;
        r.mask = mask;
        r.nonce = nonce;
        qA.push_back(r);
    endtask

    // Checks this cycle's launch (with the inputs just driven), then moves to
    // the next mid-cycle point and drops the one-cycle pulses.
    task automatic step();
        launchRec e;
        #1;
        if (aCoreStart != '0) begin
            if (qA.size() == 0) chk("a_spurious_launch", 64'(aCoreStart), 64'd0);
            else begin
                e = qA.pop_front();
                chk("a_launch_mask", 64'(aCoreStart), 64'(e.mask));
                chk("a_launch_nonce", 64'(aNonce), 64'(e.nonce));
            end
        end
        @(negedge clk);
        aStart = 1'b0;
        aAbort = 1'b0;
        aDone = '0;
        aValid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        aStart = 0; aAbort = 0; aDone = '0; aValid = '0;
        bStart = 0; bAbort = 0; bDone = '0; bValid = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_start", 64'(aCoreStart), 64'd0);
        chk("rst_a_busy", 64'(aBusy), 64'd0);
        chk("rst_a_found", 64'({aFound, aExh}), 64'd0);
        chk("rst_a_hash", 64'(aHash), 64'd0);
        chk("rst_b_busy", 64'({bBusy, bExh, bFound}), 64'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Fill all four cores in consecutive cycles, then nothing more.
        pushA(4'b0001, 0); pushA(4'b0010, 1); pushA(4'b0100, 2); pushA(4'b1000, 3);
        aStart = 1; step();
        chk("s1_busy", 64'(aBusy), 64'd1);
        repeat (6) step();
        chk("s1_pending", 64'(qA.size()), 64'd0);

        // Core 2 finishes invalid and is relaunched with nonce 4, then wins.
        aDone = 4'b0100; pushA(4'b0100, 4); step();
        step();
        chk("s2_hash1", 64'(aHash), 64'd1);
        chk("s2_pending", 64'(qA.size()), 64'd0);
        aDone = 4'b0100; aValid = 4'b0100; step();
        chk("s2_found", 64'(aFound), 64'd1);
        chk("s2_found_nonce", 64'(aFoundNonce), 64'd4);
        chk("s2_drain_busy", 64'(aBusy), 64'd1);
        aDone = 4'b0001; aValid = 4'b0001; step();
        chk("s2_first_winner_kept", 64'(aFoundNonce), 64'd4);
        aDone = 4'b0010; step();
        aDone = 4'b1000; step();
        chk("s2_busy_hold", 64'(aBusy), 64'd1);
        chk("s2_hash5", 64'(aHash), 64'd5);
        step();
        chk("s2_idle", 64'(aBusy), 64'd0);
        chk("s2_found_sticky", 64'(aFound), 64'd1);

        // Same-cycle winners on cores 1 and 3 with an abort and an idle core 0.
        pushA(4'b0001, 0); pushA(4'b0010, 1); pushA(4'b0100, 2); pushA(4'b1000, 3);
        aStart = 1; step();
        chk("s3_found_cleared", 64'(aFound), 64'd0);
        chk("s3_hash_cleared", 64'(aHash), 64'd0);
        repeat (4) step();
        aDone = 4'b0001; step();
        aDone = 4'b1010; aValid = 4'b1010; aAbort = 1; step();
        chk("s3_found", 64'(aFound), 64'd1);
        chk("s3_lowest_wins", 64'(aFoundNonce), 64'd1);
        chk("s3_hash", 64'(aHash), 64'd3);
        aDone = 4'b0100; step();
        step();
        chk("s3_idle", 64'(aBusy), 64'd0);
        chk("s3_pending", 64'(qA.size()), 64'd0);

        // Exhaustion on the 2-core, 4-bit build: every core answers after 3 cycles.
        for (int n = 0; n < 16; n++) qB.push_back(4'(n));
        bCnt[0] = 0; bCnt[1] = 0;
        bEnded = 1'b0;
        bStart = 1; #1; @(negedge clk); bStart = 0;
        for (int c = 0; c < 400; c++) begin
            bDone = '0;
            for (int k = 0; k < 2; k++) begin
                if (bCnt[k] > 0) begin
                    bCnt[k]--;
                    if (bCnt[k] == 0) bDone[k] = 1'b1;
                end
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                if (bCoreStart[k]) begin
                    bLaunches++;
                    bLast = bNonce;
                    if (qB.size() == 0) chk("b_spurious_launch", 64'(bCoreStart), 64'd0);
                    else chk("b_nonce", 64'(bNonce), 64'(qB.pop_front()));
                    bCnt[k] = 3;
                end
            end
            if (!bBusy) begin
                bEnded = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bDone = '0;
        chk("b_finished_in_budget", 64'(bEnded), 64'd1);
        chk("b_launches", 64'(bLaunches), 64'd16);
        chk("b_last_nonce", 64'(bLast), 64'd15);
        chk("b_exhausted", 64'(bExh), 64'd1);
        chk("b_hash", 64'(bHash), 64'd16);
        chk("b_found", 64'(bFound), 64'd0);
        chk("b_pending", 64'(qB.size()), 64'd0);

        // Abort with three cores busy; a start during the drain is ignored.
        pushA(4'b0001, 0); pushA(4'b0010, 1); pushA(4'b0100, 2);
        aStart = 1; step();
        repeat (3) step();
        aAbort = 1; step();
        aStart = 1; step();
        chk("s5_start_ignored", 64'(aBusy), 64'd1);
        aDone = 4'b0001; step();
        aDone = 4'b0010; step();
        aDone = 4'b0100; aValid = 4'b0100; step();
        chk("s5_busy_hold", 64'(aBusy), 64'd1);
        step();
        chk("s5_idle", 64'(aBusy), 64'd0);
        chk("s5_flags", 64'({aFound, aExh}), 64'd0);
        chk("s5_hash", 64'(aHash), 64'd3);
        chk("s5_pending", 64'(qA.size()), 64'd0);

        // Asynchronous reset mid-RUN, then a clean restart at nonce 0 on core 0.
        pushA(4'b0001, 0); pushA(4'b0010, 1); pushA(4'b0100, 2);
        aStart = 1; step();
        step(); step();
        aDone = 4'b0001; step();
        chk("s6_hash", 64'(aHash), 64'd1);
        #1;
        chk("s6_pre_reset_launch", 64'(aCoreStart), 64'd8);
        n_rst = 1'b0;
        #1;
        chk("s6_rst_start", 64'(aCoreStart), 64'd0);
        chk("s6_rst_nonce", 64'(aNonce), 64'd0);
        chk("s6_rst_busy", 64'(aBusy), 64'd0);
        chk("s6_rst_hash", 64'(aHash), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        pushA(4'b0001, 0);
        aStart = 1; step();
        step();
        chk("s6_pending", 64'(qA.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
